// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM state encoding and
// frame-length helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  // Total serial bits per frame: start + data + optional parity + stop(s).
  function automatic int frame_bits(input int data_bits, input int parity_en,
                                    input int stop_bits);
    return 1 + data_bits + parity_en + stop_bits;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts clock cycles within one serial bit and flags the
// last cycle of each bit while the transmitter is running.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 20
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  output logic bit_end
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  assign bit_end = run && (cnt == LAST);

  // Counter restarts at every bit boundary and is held at zero while idle, so
  // the first bit after acceptance gets a full period.
  always_ff @(posedge clock) begin
    if (reset || !run || bit_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: valid/ready word input, configurable data
// width, optional even/odd parity and one or two stop bits.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 20,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_BITS-1:0] in_data,
  output logic                 serial_out,
  output logic                 busy,
  output logic                 r_done
);

  // Handshake: a word transfers on a rising edge where in_valid && in_ready;
  // in_ready is high only in IDLE outside reset, and in_valid at other times
  // is ignored without queueing.

  localparam int FRAME_BITS = frame_bits(DATA_BITS, PARITY_EN, STOP_BITS);

  if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 ||
      PARITY_EN < 0 || PARITY_EN > 1 || PARITY_ODD < 0 || PARITY_ODD > 1 ||
      STOP_BITS < 1 || STOP_BITS > 2 || FRAME_BITS > 13) begin : g_bad_params
    $error("uart_tx_frame: illegal parameter combination");
  end

  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

  tx_state_t            state, state_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic [IDX_W-1:0]     bit_idx, bit_idx_n;
  logic                 par_q, par_n;
  logic                 so_q, so_n;
  logic                 busy_q, busy_n;
  logic                 done_q, done_n;
  logic                 bit_end;

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clock  (clock),
    .reset  (reset),
    .run    (state != IDLE),
    .bit_end(bit_end)
  );

  assign in_ready   = (state == IDLE) && !reset;
  assign serial_out = so_q;
  assign busy       = busy_q;
  assign r_done     = done_q;

  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    bit_idx_n = bit_idx;
    par_n     = par_q;
    so_n      = so_q;
    busy_n    = busy_q;
    done_n    = 1'b0;

    case (state)
      IDLE: begin
        so_n = 1'b1;
        if (in_valid) begin
          // Parity is taken from the word as latched, never from live in_data.
          state_n   = START;
          shreg_n   = in_data;
          par_n     = (^in_data) ^ (PARITY_ODD != 0);
          bit_idx_n = '0;
          so_n      = 1'b0;
          busy_n    = 1'b1;
        end
      end

      START: begin
        if (bit_end) begin
          state_n = DATA;
          so_n    = shreg[0];
        end
      end

      DATA: begin
        if (bit_end) begin
          shreg_n = shreg >> 1;
          if (bit_idx == LAST_DATA) begin
            bit_idx_n = '0;
            if (PARITY_EN != 0) begin
              state_n = PARITY;
              so_n    = par_q;
            end else begin
              state_n = STOP;
              so_n    = 1'b1;
            end
          end else begin
            bit_idx_n = bit_idx + IDX_W'(1);
            so_n      = shreg[1];
          end
        end
      end

      PARITY: begin
        if (bit_end) begin
          state_n = STOP;
          so_n    = 1'b1;
        end
      end

      STOP: begin
        so_n = 1'b1;
        if (bit_end) begin
          if (bit_idx == LAST_STOP) begin
            state_n   = IDLE;
            bit_idx_n = '0;
            busy_n    = 1'b0;
            done_n    = 1'b1;
          end else begin
            bit_idx_n = bit_idx + IDX_W'(1);
          end
        end
      end

      default: begin
        state_n   = IDLE;
        bit_idx_n = '0;
        so_n      = 1'b1;
        busy_n    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_idx <= '0;
      par_q   <= 1'b0;
      so_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_n;
      shreg   <= shreg_n;
      bit_idx <= bit_idx_n;
      par_q   <= par_n;
      so_q    <= so_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: five parameter variants side by side, directed
// vector table, hand sequences for back-to-back and mid-frame reset, and
// random words checked against a frame-building reference model.
module tb_uart_tx_frame;

  localparam int N = 5;
  // Variants: 0 = 8N1/20, 1 = 7E1/20, 2 = 7O1/20, 3 = 8N2/20, 4 = 8N1/2
  localparam int CPB [N] = '{20, 20, 20, 20, 2};
  localparam int DB  [N] = '{8, 7, 7, 8, 8};
  localparam int PE  [N] = '{0, 1, 1, 0, 0};
  localparam int PO  [N] = '{0, 0, 1, 0, 0};
  localparam int SB  [N] = '{1, 1, 1, 2, 1};

  logic       clock;
  logic       reset;
  logic       vld [N];
  logic [8:0] din [N];
  logic       rdy [N];
  logic       so  [N];
  logic       bsy [N];
  logic       dn  [N];

  int n_chk  = 0;
  int n_fail = 0;

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached (checks=%0d fails=%0d)", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

  uart_tx_frame #(.CLKS_PER_BIT(20), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_d0 (
    .clock(clock), .reset(reset), .in_valid(vld[0]), .in_ready(rdy[0]), .in_data(din[0][7:0]),
    .serial_out(so[0]), .busy(bsy[0]), .r_done(dn[0]));
  uart_tx_frame #(.CLKS_PER_BIT(20), .DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_d1 (
    .clock(clock), .reset(reset), .in_valid(vld[1]), .in_ready(rdy[1]), .in_data(din[1][6:0]),
    .serial_out(so[1]), .busy(bsy[1]), .r_done(dn[1]));
  uart_tx_frame #(.CLKS_PER_BIT(20), .DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_d2 (
    .clock(clock), .reset(reset), .in_valid(vld[2]), .in_ready(rdy[2]), .in_data(din[2][6:0]),
    .serial_out(so[2]), .busy(bsy[2]), .r_done(dn[2]));
  uart_tx_frame #(.CLKS_PER_BIT(20), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_d3 (
    .clock(clock), .reset(reset), .in_valid(vld[3]), .in_ready(rdy[3]), .in_data(din[3][7:0]),
    .serial_out(so[3]), .busy(bsy[3]), .r_done(dn[3]));
  uart_tx_frame #(.CLKS_PER_BIT(2), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_d4 (
    .clock(clock), .reset(reset), .in_valid(vld[4]), .in_ready(rdy[4]), .in_data(din[4][7:0]),
    .serial_out(so[4]), .busy(bsy[4]), .r_done(dn[4]));

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: the frame as an ordered list of line levels, one per bit.
  function automatic void model_frame(input int i, input logic [8:0] d,
                                      output logic [11:0] line, output int nbits);
    logic q[$];
    int ones = 0;
    q.push_back(1'b0);
    for (int b = 0; b < DB[i]; b++) begin
      q.push_back(d[b]);
      ones += int'(d[b]);
    end
    if (PE[i] == 1) q.push_back(((ones % 2) == 1) ^ (PO[i] == 1));
    for (int s = 0; s < SB[i]; s++) q.push_back(1'b1);
    line = '0;
    foreach (q[k]) line[k] = q[k];
    nbits = q.size();
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_accept(input int i, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 500; n++) begin
      @(negedge clock);
      if (rdy[i] === 1'b1) begin
        @(posedge clock);
        ok = 1'b1;
        return;
      end
    end
    n_chk++;
    n_fail++;
    $display("FAIL accept_timeout dut%0d: in_ready never high within 500 cycles", i);
  endtask

  // Called just after the acceptance edge; follows the frame cycle by cycle.
  task automatic run_frame(input int i, input logic [11:0] line, input int nbits,
                           input bit next_valid, input logic [8:0] next_data);
    #1;
    vld[i] = next_valid;
    din[i] = next_valid ? next_data : ~din[i];
    for (int k = 0; k < nbits * CPB[i]; k++) begin
      @(negedge clock);
      chk($sformatf("line dut%0d cyc%0d", i, k), so[i], line[k / CPB[i]]);
      chk($sformatf("busy dut%0d cyc%0d", i, k), bsy[i], 1'b1);
      chk($sformatf("ready dut%0d cyc%0d", i, k), rdy[i], 1'b0);
      chk($sformatf("done_early dut%0d cyc%0d", i, k), dn[i], 1'b0);
    end
    @(negedge clock);
    chk($sformatf("done dut%0d", i), dn[i], 1'b1);
    chk($sformatf("busy_end dut%0d", i), bsy[i], 1'b0);
    chk($sformatf("idle_line dut%0d", i), so[i], 1'b1);
    chk($sformatf("ready_end dut%0d", i), rdy[i], 1'b1);
    if (next_valid) begin
      @(posedge clock);
    end else begin
      @(negedge clock);
      chk($sformatf("done_width dut%0d", i), dn[i], 1'b0);
      chk($sformatf("line_after dut%0d", i), so[i], 1'b1);
    end
  endtask

  task automatic send(input int i, input logic [8:0] d, input logic [11:0] line, input int nbits);
    bit ok;
    vld[i] = 1'b1;
    din[i] = d;
    wait_accept(i, ok);
    if (ok) run_frame(i, line, nbits, 1'b0, '0);
    else vld[i] = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int          inst;
    logic [8:0]  data;
    logic [11:0] line;   // expected line levels, bit 0 = start bit
    int          nbits;
  } vec_t;

  vec_t vecs [5];

  initial begin
    bit          ok;
    logic [11:0] mline;
    int          mbits;
    int          ri;
    logic [8:0]  rd;

    vecs[0] = '{0, 9'h0A5, 12'h34A, 10};  // 0 10100101 1 -> 0,1,0,1,0,0,1,0,1,1
    vecs[1] = '{1, 9'h041, 12'h282, 10};  // 7E1, two ones -> parity 0
    vecs[2] = '{2, 9'h041, 12'h382, 10};  // 7O1 -> parity 1
    vecs[3] = '{3, 9'h000, 12'h600, 11};  // two stop bits, 220 cycles
    vecs[4] = '{4, 9'h055, 12'h2AA, 10};  // 2 clocks per bit

    reset = 1'b1;
    for (int i = 0; i < N; i++) begin
      vld[i] = 1'b0;
      din[i] = '0;
    end
    repeat (3) @(posedge clock);
    // in_valid during reset must not be accepted
    #1 vld[0] = 1'b1;
    din[0] = 9'h0FF;
    @(negedge clock);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("rst_line dut%0d", i), so[i], 1'b1);
      chk($sformatf("rst_ready dut%0d", i), rdy[i], 1'b0);
      chk($sformatf("rst_busy dut%0d", i), bsy[i], 1'b0);
      chk($sformatf("rst_done dut%0d", i), dn[i], 1'b0);
    end
    @(posedge clock);
    #1 reset = 1'b0;
    vld[0] = 1'b0;
    @(negedge clock);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("post_rst_ready dut%0d", i), rdy[i], 1'b1);
      chk($sformatf("post_rst_busy dut%0d", i), bsy[i], 1'b0);
    end

    for (int v = 0; v < 5; v++) begin
      send(vecs[v].inst, vecs[v].data, vecs[v].line, vecs[v].nbits);
    end

    // Back-to-back with in_valid held: 0x00 then 0xFF, one idle cycle between
    vld[0] = 1'b1;
    din[0] = 9'h000;
    wait_accept(0, ok);
    if (ok) begin
      run_frame(0, 12'h200, 10, 1'b1, 9'h0FF);
      run_frame(0, 12'h3FE, 10, 1'b0, '0);
    end

    // Reset during data bit 3 abandons the frame without r_done
    vld[0] = 1'b1;
    din[0] = 9'h05A;
    wait_accept(0, ok);
    #1 vld[0] = 1'b0;
    repeat (CPB[0] * 4 + 3) @(negedge clock);
    chk("mid_busy", bsy[0], 1'b1);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk("mid_rst_line", so[0], 1'b1);
    chk("mid_rst_busy", bsy[0], 1'b0);
    chk("mid_rst_done", dn[0], 1'b0);
    chk("mid_rst_ready", rdy[0], 1'b0);
    reset = 1'b0;
    for (int k = 0; k < 250; k++) begin
      @(negedge clock);
      chk($sformatf("abandon_done cyc%0d", k), dn[0], 1'b0);
      chk($sformatf("abandon_line cyc%0d", k), so[0], 1'b1);
    end
    send(0, 9'h03C, 12'h278, 10);

    // Random words on random variants against the frame model
    for (int r = 0; r < 15; r++) begin
      ri = int'($urandom_range(0, N - 1));
      rd = 9'($urandom);
      model_frame(ri, rd, mline, mbits);
      send(ri, rd, mline, mbits);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
